// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: classifies the instruction, reads operands and queues bundles in a DEPTH-entry FIFO.
// Define DECODE_WB_BYPASS_EN to forward the writeback port onto same-cycle operand reads.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      regfile_addr1_o,
    output logic [4:0]      regfile_addr2_o,
    input  logic [XLEN-1:0] regfile_data1_i,
    input  logic [XLEN-1:0] regfile_data2_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [3:0]      op_class_o,
    output logic [2:0]      funct3_o,
    output logic            alt_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam bit IS_RV64 = (XLEN == 64);
    // RV64 uses inst[25] as the top shamt bit, so it is excluded from the funct7 check
    localparam logic [6:0] SHIFT_HI_MASK = IS_RV64 ? 7'b1111110 : 7'b1111111;

    localparam logic [3:0] CLS_OP        = 4'd0;
    localparam logic [3:0] CLS_OP_IMM    = 4'd1;
    localparam logic [3:0] CLS_SHIFT_IMM = 4'd2;
    localparam logic [3:0] CLS_LUI       = 4'd3;
    localparam logic [3:0] CLS_AUIPC     = 4'd4;
    localparam logic [3:0] CLS_JAL       = 4'd5;
    localparam logic [3:0] CLS_JALR      = 4'd6;
    localparam logic [3:0] CLS_BRANCH    = 4'd7;
    localparam logic [3:0] CLS_LOAD      = 4'd8;
    localparam logic [3:0] CLS_STORE     = 4'd9;
    localparam logic [3:0] CLS_ILLEGAL   = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [3:0]      op_class;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } bundle_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [6:0]      shift_hi_s;
    logic [5:0]      shamt_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [31:0]     imm_i_s;
    logic [31:0]     imm_st_s;
    logic [31:0]     imm_b_s;
    logic [31:0]     imm_u_s;
    logic [31:0]     imm_j_s;
    logic            load_bad_s;
    logic            store_bad_s;
    logic [3:0]      class_s;
    logic [XLEN-1:0] imm_s;
    logic [4:0]      rd_s;
    logic            alt_s;
    logic            byp1_s;
    logic            byp2_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    bundle_t         bundle_s;
    bundle_t         head_s;
    logic            push_s;
    logic            pop_s;

    bundle_t         mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    assign opcode_s   = inst_i[6:0];
    assign funct3_s   = inst_i[14:12];
    assign funct7_s   = inst_i[31:25];
    assign shift_hi_s = inst_i[31:25] & SHIFT_HI_MASK;
    assign shamt_s    = IS_RV64 ? inst_i[25:20] : {1'b0, inst_i[24:20]};
    assign rs1_s      = inst_i[19:15];
    assign rs2_s      = inst_i[24:20];
    assign imm_i_s    = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_st_s   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b_s    = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u_s    = {inst_i[31:12], 12'h000};
    assign imm_j_s    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign load_bad_s  = (funct3_s == 3'b111) || (!IS_RV64 && ((funct3_s == 3'b011) || (funct3_s == 3'b110)));
    assign store_bad_s = IS_RV64 ? (funct3_s > 3'b011) : (funct3_s > 3'b010);

    // Instruction classification and legality
    always_comb begin
        class_s = CLS_ILLEGAL;
        if (inst_i[1:0] != 2'b11) begin
            class_s = CLS_ILLEGAL;
        end else begin
            case (opcode_s)
                OPC_OP: begin
                    if ((funct7_s == 7'b0000000) ||
                        ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
                        class_s = CLS_OP;
                    end else begin
                        class_s = CLS_ILLEGAL;
                    end
                end
                OPC_OP_IMM: begin
                    if (funct3_s == 3'b001) begin
                        class_s = (shift_hi_s == 7'b0000000) ? CLS_SHIFT_IMM : CLS_ILLEGAL;
                    end else if (funct3_s == 3'b101) begin
                        class_s = ((shift_hi_s == 7'b0000000) || (shift_hi_s == 7'b0100000)) ? CLS_SHIFT_IMM : CLS_ILLEGAL;
                    end else begin
                        class_s = CLS_OP_IMM;
                    end
                end
                OPC_LUI:    class_s = CLS_LUI;
                OPC_AUIPC:  class_s = CLS_AUIPC;
                OPC_JAL:    class_s = CLS_JAL;
                OPC_JALR:   class_s = (funct3_s == 3'b000) ? CLS_JALR : CLS_ILLEGAL;
                OPC_BRANCH: class_s = ((funct3_s == 3'b010) || (funct3_s == 3'b011)) ? CLS_ILLEGAL : CLS_BRANCH;
                OPC_LOAD:   class_s = load_bad_s ? CLS_ILLEGAL : CLS_LOAD;
                OPC_STORE:  class_s = store_bad_s ? CLS_ILLEGAL : CLS_STORE;
                default:    class_s = CLS_ILLEGAL;
            endcase
        end
    end

    // Immediate, destination and alternate-op selection by class
    always_comb begin
        imm_s = '0;
        rd_s  = inst_i[11:7];
        alt_s = 1'b0;
        case (class_s)
            CLS_OP:                          alt_s = inst_i[30];
            CLS_OP_IMM, CLS_JALR, CLS_LOAD:  imm_s = sext32(imm_i_s);
            CLS_SHIFT_IMM: begin
                imm_s = XLEN'(shamt_s);
                alt_s = inst_i[30];
            end
            CLS_LUI, CLS_AUIPC:              imm_s = sext32(imm_u_s);
            CLS_JAL:                         imm_s = sext32(imm_j_s);
            CLS_BRANCH: begin
                imm_s = sext32(imm_b_s);
                rd_s  = 5'd0;
            end
            CLS_STORE: begin
                imm_s = sext32(imm_st_s);
                rd_s  = 5'd0;
            end
            default:                         rd_s  = 5'd0;
        endcase
    end

`ifdef DECODE_WB_BYPASS_EN
    assign byp1_s = wb_en_i && (wb_addr_i == rs1_s);
    assign byp2_s = wb_en_i && (wb_addr_i == rs2_s);
`else
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_en_i, wb_addr_i};
    assign byp1_s = 1'b0;
    assign byp2_s = 1'b0;
`endif

    // x0 always reads as zero, even when a writeback targets it
    assign rs1_val_s = (rs1_s == 5'd0) ? '0 : (byp1_s ? wb_data_i : regfile_data1_i);
    assign rs2_val_s = (rs2_s == 5'd0) ? '0 : (byp2_s ? wb_data_i : regfile_data2_i);
    assign regfile_addr1_o = rs1_s;
    assign regfile_addr2_o = rs2_s;

    assign bundle_s = '{op_class: class_s, funct3: funct3_s, alt: alt_s, rd: rd_s,
                        rs1_val: rs1_val_s, rs2_val: rs2_val_s, imm: imm_s, pc: pc_i};

    assign ready_o = (count_r < DEPTH_C);
    assign valid_o = (count_r != CW'(0));
    assign push_s  = valid_i && ready_o && !flush_i;
    assign pop_s   = valid_o && ready_i;

    // Bundle storage, written at the tail on push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= bundle_s;
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides push and pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s     = mem_r[rd_ptr_r];
    assign op_class_o = head_s.op_class;
    assign funct3_o   = head_s.funct3;
    assign alt_o      = head_s.alt;
    assign rd_o       = head_s.rd;
    assign rs1_val_o  = head_s.rs1_val;
    assign rs2_val_o  = head_s.rs2_val;
    assign imm_o      = head_s.imm;
    assign pc_o       = head_s.pc;
    assign illegal_o  = (head_s.op_class == CLS_ILLEGAL);
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=32, DEPTH=2) against a behavioural decode model and FIFO queue.
module tb_decode_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0]  op_class;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } bundle_t;

    logic        clk, rst_ni, flush_i, valid_i, ready_o, ready_i, valid_o;
    logic        wb_en_i, alt_o, illegal_o;
    logic [31:0] inst_i, pc_i, regfile_data1_i, regfile_data2_i, wb_data_i;
    logic [31:0] rs1_val_o, rs2_val_o, imm_o, pc_o;
    logic [4:0]  regfile_addr1_o, regfile_addr2_o, wb_addr_i, rd_o;
    logic [3:0]  op_class_o;
    logic [2:0]  funct3_o;
    logic [31:0] rf [32];
    logic [6:0]  ops [9];
    bundle_t     got;
    bundle_t     exp_q [$];
    int          checks;
    int          errors;

    assign regfile_data1_i = rf[regfile_addr1_o];
    assign regfile_data2_i = rf[regfile_addr2_o];
    assign got = {op_class_o, funct3_o, alt_o, rd_o, rs1_val_o, rs2_val_o, imm_o, pc_o, illegal_o};

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .regfile_addr1_o(regfile_addr1_o), .regfile_addr2_o(regfile_addr2_o),
        .regfile_data1_i(regfile_data1_i), .regfile_data2_i(regfile_data2_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .valid_o(valid_o), .ready_i(ready_i), .op_class_o(op_class_o), .funct3_o(funct3_o),
        .alt_o(alt_o), .rd_o(rd_o), .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o),
        .imm_o(imm_o), .pc_o(pc_o), .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural decode: class from opcode tables, immediates from signed integer arithmetic
    function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                           input logic [31:0] r1, input logic [31:0] r2,
                                           input logic wen, input logic [4:0] wa, input logic [31:0] wd);
        bundle_t b;
        int f3, f7, cls, si;
        logic [4:0] a1, a2;
        logic byp_en;
        f3 = int'(inst[14:12]);
        f7 = int'(inst[31:25]);
        si = $signed(inst);
        case (inst[6:0])
            7'h33: cls = (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) ? 0 : 15;
            7'h13: begin
                if (f3 == 1)      cls = (f7 == 0) ? 2 : 15;
                else if (f3 == 5) cls = (f7 == 0 || f7 == 32) ? 2 : 15;
                else              cls = 1;
            end
            7'h37: cls = 3;
            7'h17: cls = 4;
            7'h6F: cls = 5;
            7'h67: cls = (f3 == 0) ? 6 : 15;
            7'h63: cls = (f3 == 2 || f3 == 3) ? 15 : 7;
            7'h03: cls = (f3 == 3 || f3 == 6 || f3 == 7) ? 15 : 8;
            7'h23: cls = (f3 > 2) ? 15 : 9;
            default: cls = 15;
        endcase
        b.op_class = 4'(cls);
        b.funct3   = inst[14:12];
        b.alt      = (cls == 0 || cls == 2) ? inst[30] : 1'b0;
        b.rd       = (cls == 7 || cls == 9 || cls == 15) ? 5'd0 : inst[11:7];
        case (cls)
            1, 6, 8: b.imm = si >>> 20;
            2:       b.imm = 32'(inst[24:20]);
            3, 4:    b.imm = inst & 32'hFFFF_F000;
            5:       b.imm = ((si >>> 31) << 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
            7:       b.imm = ((si >>> 31) << 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
            9:       b.imm = ((si >>> 25) << 5) | int'(inst[11:7]);
            default: b.imm = 32'd0;
        endcase
`ifdef DECODE_WB_BYPASS_EN
        byp_en = 1'b1;
`else
        byp_en = 1'b0;
`endif
        a1 = inst[19:15];
        a2 = inst[24:20];
        b.rs1_val = (a1 == 5'd0) ? 32'd0 : r1;
        b.rs2_val = (a2 == 5'd0) ? 32'd0 : r2;
        if (byp_en && wen && wa == a1 && a1 != 5'd0) b.rs1_val = wd;
        if (byp_en && wen && wa == a2 && a2 != 5'd0) b.rs2_val = wd;
        b.pc      = pc;
        b.illegal = (cls == 15);
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = int'($urandom_range(0, 11));
        if (k < 9) begin
            w[6:0] = ops[k];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    // One clock: model push/pop from current inputs, then return at the next falling edge
    task automatic tick();
        bundle_t e;
        logic push, pop;
        push = valid_i && (exp_q.size() < DEPTH) && !flush_i;
        pop  = (exp_q.size() > 0) && ready_i;
        e = ref_decode(inst_i, pc_i, rf[inst_i[19:15]], rf[inst_i[24:20]], wb_en_i, wb_addr_i, wb_data_i);
        @(posedge clk);
        if (flush_i) begin
            exp_q.delete();
        end else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; wb_en_i = 1'b0;
        repeat (DEPTH + 1) tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty: valid_o=%b want 0", valid_o); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        checks++; if (got !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", got); end
        rst_ni = 1'b1;
        exp_q.delete();
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_release: valid_o=%b want 0", valid_o); end
    endtask

    task automatic test_addi();
        rf[2] = 32'd5; rf[31] = 32'h0000_0031;
        inst_i = 32'hFFF1_0093; pc_i = 32'h0000_0100; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", valid_o); end
        checks++; if (op_class_o !== 4'd1) begin errors++; $display("FAIL addi_class: got %0d want 1", op_class_o); end
        checks++; if (rd_o !== 5'd1 || funct3_o !== 3'd0) begin errors++; $display("FAIL addi_rd_f3: got %0d/%0d want 1/0", rd_o, funct3_o); end
        checks++; if (rs1_val_o !== 32'd5) begin errors++; $display("FAIL addi_rs1: got %h want 5", rs1_val_o); end
        checks++; if (imm_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm: got %h want ffffffff", imm_o); end
        checks++; if (illegal_o !== 1'b0 || pc_o !== 32'h100) begin errors++; $display("FAIL addi_ill_pc: got %b/%h want 0/100", illegal_o, pc_o); end
        checks++; if (rs2_val_o !== 32'h31) begin errors++; $display("FAIL addi_rs2: got %h want 31", rs2_val_o); end
        drain();
    endtask

    task automatic test_lui_auipc();
        inst_i = 32'h1234_52B7; pc_i = 32'h0000_0200; valid_i = 1'b1; ready_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b1 || op_class_o !== 4'd3 || rd_o !== 5'd5) begin errors++; $display("FAIL lui_head: got v%b c%0d rd%0d want v1 c3 rd5", valid_o, op_class_o, rd_o); end
        checks++; if (imm_o !== 32'h1234_5000 || pc_o !== 32'h200) begin errors++; $display("FAIL lui_imm_pc: got %h/%h want 12345000/200", imm_o, pc_o); end
        inst_i = 32'h1234_5317; pc_i = 32'h0000_0204;
        tick();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || op_class_o !== 4'd4) begin errors++; $display("FAIL auipc_head: got v%b c%0d want v1 c4", valid_o, op_class_o); end
        checks++; if (imm_o !== 32'h1234_5000 || pc_o !== 32'h204) begin errors++; $display("FAIL auipc_imm_pc: got %h/%h want 12345000/204", imm_o, pc_o); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] insts [3];
        bundle_t e [3];
        bundle_t seen [$];
        logic pushed;
        insts = '{32'h0050_0113, 32'h1234_52B7, 32'h0020_81B3};
        for (int k = 0; k < 3; k++)
            e[k] = ref_decode(insts[k], 32'h300 + 32'(4 * k), rf[insts[k][19:15]], rf[insts[k][24:20]], 1'b0, 5'd0, 32'd0);
        ready_i = 1'b0; valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_i = insts[k]; pc_i = 32'h300 + 32'(4 * k);
            tick();
            if (k >= 1) begin
                checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", k, ready_o); end
            end
        end
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (valid_o === 1'b1) seen.push_back(got);
            pushed = valid_i && (exp_q.size() < DEPTH);
            tick();
            if (pushed) valid_i = 1'b0;
        end
        checks++; if (seen.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", seen.size()); end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            checks++; if (seen[k] !== e[k]) begin errors++; $display("FAIL bp_order_%0d: got %h want %h", k, seen[k], e[k]); end
        end
        drain();
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        words = '{32'h0000_0000, 32'h0000_2463, 32'h4000_10B3};
        ready_i = 1'b1; valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst_i = words[k]; pc_i = 32'h400 + 32'(4 * k);
            tick();
            checks++; if (op_class_o !== 4'd15 || illegal_o !== 1'b1 || rd_o !== 5'd0) begin
                errors++; $display("FAIL illegal_%0d: got c%0d ill%b rd%0d want c15 ill1 rd0", k, op_class_o, illegal_o, rd_o);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        inst_i = 32'h0010_0093; pc_i = 32'h500; tick();
        inst_i = 32'h0020_0113; pc_i = 32'h504; tick();
        inst_i = 32'h0030_0193; pc_i = 32'h508; flush_i = 1'b1; tick();
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", ready_o); end
        ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_leak_%0d: valid_o=%b want 0", c, valid_o); end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef DECODE_WB_BYPASS_EN
        want = 32'h0000_00AA;
`else
        want = 32'h0000_0011;
`endif
        rf[2] = 32'h0000_0011;
        inst_i = 32'h0001_01B3; pc_i = 32'h600; valid_i = 1'b1; ready_i = 1'b1;
        wb_en_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'h0000_00AA;
        tick();
        valid_i = 1'b0; wb_en_i = 1'b0;
        checks++; if (rs1_val_o !== want) begin errors++; $display("FAIL bypass_rs1: got %h want %h", rs1_val_o, want); end
        checks++; if (rs2_val_o !== 32'd0) begin errors++; $display("FAIL bypass_rs2: got %h want 0", rs2_val_o); end
        checks++; if (op_class_o !== 4'd0 || rd_o !== 5'd3) begin errors++; $display("FAIL bypass_add: got c%0d rd%0d want c0 rd3", op_class_o, rd_o); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            valid_i   = ($urandom_range(0, 3) != 0);
            ready_i   = ($urandom_range(0, 3) != 0);
            flush_i   = ($urandom_range(0, 24) == 0);
            inst_i    = rand_inst();
            pc_i      = $urandom & 32'hFFFF_FFFC;
            wb_en_i   = ($urandom_range(0, 1) == 1);
            wb_addr_i = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            rf[5'($urandom_range(1, 31))] = $urandom;
            checks++; if (ready_o !== (exp_q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready[%0d]: got %b model size %0d", i, ready_o, exp_q.size()); end
            checks++; if (valid_o !== (exp_q.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b model size %0d", i, valid_o, exp_q.size()); end
            if (exp_q.size() > 0) begin
                checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL rand_head[%0d]: got %h want %h", i, got, exp_q[0]); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0; valid_i = 1'b1;
        inst_i = 32'h0010_0093; pc_i = 32'h700; tick();
        inst_i = 32'h0020_0113; pc_i = 32'h704; tick();
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL areset_flags: got v%b r%b want v0 r1", valid_o, ready_o); end
        checks++; if (got !== '0) begin errors++; $display("FAIL areset_payload: got %h want 0", got); end
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL areset_emit_%0d: valid_o=%b want 0", c, valid_o); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        inst_i = 32'd0; pc_i = 32'd0; wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        test_reset();
        test_addi();
        test_lui_auipc();
        test_backpressure();
        test_illegal();
        test_flush();
        test_bypass();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
